// File: rtl/image_rom_streamer_if.sv
`default_nettype none
// ============================================================================
// Module : image_rom_streamer_if
// Brief  : Control, ROM-port and pixel-stream bundle for image_rom_streamer.
// Rev    : 1.0  initial release
// ============================================================================
interface image_rom_streamer_if #(
  parameter int WIDTH_BITS  = 7,
  parameter int HEIGHT_BITS = 7,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = WIDTH_BITS + HEIGHT_BITS
);
  logic                   iStart;
  logic                   iLoop;
  logic                   oBusy;
  logic                   oDone;
  logic [ADDR_WIDTH-1:0]  oRomAddr;
  logic                   oRomRe;
  logic [DATA_WIDTH-1:0]  iRomData;
  logic                   oValid;
  logic                   iReady;
  logic [DATA_WIDTH-1:0]  oData;
  logic [WIDTH_BITS-1:0]  oCol;
  logic [HEIGHT_BITS-1:0] oRow;
  logic                   oSof;
  logic                   oEol;
  logic                   oEof;

  modport slave (
    input  iStart, iLoop, iRomData, iReady,
    output oBusy, oDone, oRomAddr, oRomRe, oValid, oData, oCol, oRow,
           oSof, oEol, oEof
  );

  modport master (
    output iStart, iLoop, iRomData, iReady,
    input  oBusy, oDone, oRomAddr, oRomRe, oValid, oData, oCol, oRow,
           oSof, oEol, oEof
  );
endinterface
`default_nettype wire

// File: rtl/image_rom_streamer.sv
`default_nettype none
// ============================================================================
// Module : image_rom_streamer
// Brief  : Raster-order reader of a synchronous ROM, streaming pixels with
//          coordinates and frame/line markers over valid/ready.
// Rev    : 1.0  initial release
// ============================================================================
module image_rom_streamer #(
  parameter int WIDTH_BITS  = 7,
  parameter int HEIGHT_BITS = 7,
  parameter int IMG_W       = 128,
  parameter int IMG_H       = 128,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = WIDTH_BITS + HEIGHT_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  image_rom_streamer_if.slave  bus
);

  localparam logic [WIDTH_BITS-1:0]  C_LAST_COL = WIDTH_BITS'(IMG_W - 1);
  localparam logic [HEIGHT_BITS-1:0] C_LAST_ROW = HEIGHT_BITS'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  data;
    logic [WIDTH_BITS-1:0]  col;
    logic [HEIGHT_BITS-1:0] row;
    logic                   sof;
    logic                   eol;
    logic                   eof;
  } entry_t;

  state_t                 r_state;
  logic [WIDTH_BITS-1:0]  r_col;
  logic [HEIGHT_BITS-1:0] r_row;
  logic                   r_done;

  logic                   r_inflight;
  logic [WIDTH_BITS-1:0]  r_if_col;
  logic [HEIGHT_BITS-1:0] r_if_row;
  logic                   r_if_sof;
  logic                   r_if_eol;
  logic                   r_if_eof;

  entry_t                 r_fifo [0:1];
  logic                   r_wr_ptr;
  logic                   r_rd_ptr;
  logic [1:0]             r_count;

  logic                   w_pop;
  logic                   w_push;
  logic [2:0]             w_occ;
  logic                   w_re;
  logic                   w_col_last;
  logic                   w_row_last;
  logic                   w_frame_end;
  entry_t                 w_head;

  assign w_head     = r_fifo[r_rd_ptr];
  assign w_pop      = (r_count != 2'd0) && bus.iReady;
  assign w_push     = r_inflight;
  assign w_occ      = {1'b0, r_count} + {2'b00, r_inflight};
  // A word leaving this cycle frees a slot, so it may be reused by the read issued now.
  assign w_re       = (r_state == S_RUN) && (w_occ < (3'd2 + {2'b00, w_pop}));
  assign w_col_last = (r_col == C_LAST_COL);
  assign w_row_last = (r_row == C_LAST_ROW);
  assign w_frame_end = (r_state == S_DRAIN) && !r_inflight && (r_count == 2'd1)
                       && w_pop && w_head.eof;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.iStart) begin
            r_col   <= '0;
            r_row   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_re) begin
            if (w_col_last) begin
              r_col <= '0;
              if (w_row_last) begin
                r_row   <= '0;
                r_state <= S_DRAIN;
              end else begin
                r_row <= r_row + 1'b1;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_frame_end) begin
            r_done  <= 1'b1;
            r_col   <= '0;
            r_row   <= '0;
            r_state <= bus.iLoop ? S_RUN : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Coordinates and markers travel beside the read so they meet the ROM data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_inflight <= 1'b0;
      r_if_col   <= '0;
      r_if_row   <= '0;
      r_if_sof   <= 1'b0;
      r_if_eol   <= 1'b0;
      r_if_eof   <= 1'b0;
    end else begin
      r_inflight <= w_re;
      if (w_re) begin
        r_if_col <= r_col;
        r_if_row <= r_row;
        r_if_sof <= (r_col == '0) && (r_row == '0);
        r_if_eol <= w_col_last;
        r_if_eof <= w_col_last && w_row_last;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        r_fifo[k] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= '{data: bus.iRomData, col: r_if_col, row: r_if_row,
                              sof: r_if_sof, eol: r_if_eol, eof: r_if_eof};
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.oRomAddr = ADDR_WIDTH'({r_row, r_col});
  assign bus.oRomRe   = w_re;
  assign bus.oBusy    = (r_state != S_IDLE);
  assign bus.oDone    = r_done;
  assign bus.oValid   = (r_count != 2'd0);
  assign bus.oData    = w_head.data;
  assign bus.oCol     = w_head.col;
  assign bus.oRow     = w_head.row;
  assign bus.oSof     = w_head.sof;
  assign bus.oEol     = w_head.eol;
  assign bus.oEof     = w_head.eof;

endmodule
`default_nettype wire

// File: tb/tb_image_rom_streamer.sv
`default_nettype none
// ============================================================================
// Module : tb_image_rom_streamer
// Brief  : Directed bench: 5x3 window in an 8x4 ROM, plus a 1x1 instance.
// Rev    : 1.0  initial release
// ============================================================================
module tb_image_rom_streamer;

  localparam int WB = 3;
  localparam int HB = 2;
  localparam int IW = 5;
  localparam int IH = 3;
  localparam int DW = 8;
  localparam int AW = WB + HB;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  image_rom_streamer_if #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  image_rom_streamer_if #(.WIDTH_BITS(1), .HEIGHT_BITS(1), .DATA_WIDTH(DW), .ADDR_WIDTH(2)) tiny ();

  image_rom_streamer #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB), .IMG_W(IW), .IMG_H(IH),
                       .DATA_WIDTH(DW), .ADDR_WIDTH(AW))
    dut (.clock(clock), .reset(reset), .bus(bus));

  image_rom_streamer #(.WIDTH_BITS(1), .HEIGHT_BITS(1), .IMG_W(1), .IMG_H(1),
                       .DATA_WIDTH(DW), .ADDR_WIDTH(2))
    dut1 (.clock(clock), .reset(reset), .bus(tiny));

  // Synchronous ROM with ROM[a] = a
  always @(posedge clock) begin
    bus.iRomData  <= DW'(bus.oRomAddr);
    tiny.iRomData <= DW'(tiny.oRomAddr);
  end

  typedef struct { int data; int col; int row; int sof; int eol; int eof; } word_t;
  typedef struct { int start; int ready; int re; int addr; int valid; int data;
                   int sof; int eol; int eof; int done; int busy; } vec_t;

  word_t exp_words [15];
  vec_t  vec [13];

  int checks = 0;
  int errors = 0;
  int m_cnt  = 0;
  int m_infl = 0;
  bit s_pop  = 1'b0;
  bit s_re   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    m_cnt  = m_cnt + m_infl - int'(s_pop);
    m_infl = int'(s_re);
    #1;
  endtask

  task automatic sample();
    #1;
    s_re  = bus.oRomRe;
    s_pop = bus.oValid && bus.iReady;
    chk("valid_vs_occupancy", 32'(bus.oValid), 32'(m_cnt != 0));
    if (s_re) chk("issue_rule", 32'((m_cnt + m_infl - int'(s_pop)) < 2), 32'd1);
  endtask

  task automatic model_clear();
    m_cnt = 0; m_infl = 0; s_pop = 1'b0; s_re = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.oValid), 0);
    chk({tag, "_busy"},  32'(bus.oBusy), 0);
    chk({tag, "_done"},  32'(bus.oDone), 0);
    chk({tag, "_re"},    32'(bus.oRomRe), 0);
    chk({tag, "_addr"},  32'(bus.oRomAddr), 0);
    chk({tag, "_data"},  32'(bus.oData), 0);
    chk({tag, "_colrow"}, 32'({bus.oCol, bus.oRow}), 0);
    chk({tag, "_marks"}, 32'({bus.oSof, bus.oEol, bus.oEof}), 0);
  endtask

  task automatic do_start();
    tick(); bus.iStart = 1'b1; sample();
    chk("start_idle_busy", 32'(bus.oBusy), 0);
    tick(); bus.iStart = 1'b0; sample();
    chk("start_busy", 32'(bus.oBusy), 1);
    chk("start_re",   32'(bus.oRomRe), 1);
    chk("start_addr", 32'(bus.oRomAddr), 0);
    chk("start_valid", 32'(bus.oValid), 0);
  endtask

  task automatic run_words(input bit rnd, input int n_words, input int budget,
                           input int drop_loop_at, input int start_at,
                           output int cycles, output int dones, output int max_gap);
    int idx = 0;
    int gap = 0;
    bit stall = 1'b0;
    bit pulsed = 1'b0;
    word_t held;
    cycles = 0; dones = 0; max_gap = 0;
    held = '{0, 0, 0, 0, 0, 0};
    while (idx < n_words && cycles < budget) begin
      tick();
      bus.iReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.iStart = 1'b0;
      if (idx == start_at && !pulsed) begin
        bus.iStart = 1'b1;
        pulsed = 1'b1;
      end
      if (idx >= drop_loop_at) bus.iLoop = 1'b0;
      sample();
      cycles++;
      if (bus.oDone) dones++;
      if (stall) begin
        chk("stall_data",   32'(bus.oData), held.data);
        chk("stall_colrow", 32'({bus.oCol, bus.oRow}), 32'({WB'(held.col), HB'(held.row)}));
        chk("stall_marks",  32'({bus.oSof, bus.oEol, bus.oEof}),
            32'({1'(held.sof), 1'(held.eol), 1'(held.eof)}));
      end
      if (s_pop) begin
        chk($sformatf("w%0d_data", idx), 32'(bus.oData), exp_words[idx % 15].data);
        chk($sformatf("w%0d_col", idx),  32'(bus.oCol),  exp_words[idx % 15].col);
        chk($sformatf("w%0d_row", idx),  32'(bus.oRow),  exp_words[idx % 15].row);
        chk($sformatf("w%0d_marks", idx), 32'({bus.oSof, bus.oEol, bus.oEof}),
            32'({1'(exp_words[idx % 15].sof), 1'(exp_words[idx % 15].eol),
                 1'(exp_words[idx % 15].eof)}));
        idx++;
      end
      if (bus.oValid) begin
        if (gap > max_gap) max_gap = gap;
        gap = 0;
      end else begin
        gap++;
      end
      stall = bus.oValid && !bus.iReady;
      held = '{int'(bus.oData), int'(bus.oCol), int'(bus.oRow),
               int'(bus.oSof), int'(bus.oEol), int'(bus.oEof)};
    end
    bus.iStart = 1'b0;
    chk("stream_complete", idx, n_words);
  endtask

  task automatic expect_done_then_idle(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      tick(); sample();
      if (bus.oDone) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 1);
    chk({tag, "_busy_at_done"}, 32'(bus.oBusy), 0);
    tick(); sample();
    chk({tag, "_done_pulse"}, 32'(bus.oDone), 0);
    chk({tag, "_idle_re"}, 32'(bus.oRomRe), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int cyc, dn, gp;
    exp_words[0]  = '{0,  0, 0, 1, 0, 0};
    exp_words[1]  = '{1,  1, 0, 0, 0, 0};
    exp_words[2]  = '{2,  2, 0, 0, 0, 0};
    exp_words[3]  = '{3,  3, 0, 0, 0, 0};
    exp_words[4]  = '{4,  4, 0, 0, 1, 0};
    exp_words[5]  = '{8,  0, 1, 0, 0, 0};
    exp_words[6]  = '{9,  1, 1, 0, 0, 0};
    exp_words[7]  = '{10, 2, 1, 0, 0, 0};
    exp_words[8]  = '{11, 3, 1, 0, 0, 0};
    exp_words[9]  = '{12, 4, 1, 0, 1, 0};
    exp_words[10] = '{16, 0, 2, 0, 0, 0};
    exp_words[11] = '{17, 1, 2, 0, 0, 0};
    exp_words[12] = '{18, 2, 2, 0, 0, 0};
    exp_words[13] = '{19, 3, 2, 0, 0, 0};
    exp_words[14] = '{20, 4, 2, 0, 1, 1};
    //             start rdy re addr vld data sof eol eof done busy
    vec[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vec[1]  = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    vec[2]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    vec[3]  = '{0, 1, 0, 0, 1, 0, 1, 1, 1, 0, 1};
    vec[4]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    vec[5]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vec[6]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vec[7]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    vec[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    vec[9]  = '{0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 1};
    vec[10] = '{0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 1};
    vec[11] = '{0, 1, 0, 0, 1, 0, 1, 1, 1, 0, 1};
    vec[12] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};

    reset = 1'b1;
    bus.iStart = 1'b0; bus.iLoop = 1'b0; bus.iReady = 1'b1;
    tiny.iStart = 1'b0; tiny.iLoop = 1'b0; tiny.iReady = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_zero("reset");
    chk("tiny_reset_valid", 32'({tiny.oValid, tiny.oBusy}), 0);
    reset = 1'b0;

    // Full-rate frame
    do_start();
    run_words(1'b0, 15, 40, 1000, -1, cyc, dn, gp);
    chk("full_rate_cycles", cyc, 16);
    expect_done_then_idle("f1");

    // Random backpressure, same stream expected
    do_start();
    run_words(1'b1, 15, 400, 1000, -1, cyc, dn, gp);
    expect_done_then_idle("rnd");

    // Two looped frames, iLoop dropped during the second
    bus.iLoop = 1'b1;
    do_start();
    run_words(1'b0, 30, 80, 20, -1, cyc, dn, gp);
    chk("loop_dones_between", dn, 1);
    chk("loop_gap", gp, 2);
    chk("loop_cycles", cyc, 33);
    expect_done_then_idle("loop");

    // Start pulse while running is ignored
    do_start();
    run_words(1'b0, 15, 40, 1000, 6, cyc, dn, gp);
    expect_done_then_idle("rs");
    for (int k = 0; k < 3; k++) begin
      tick(); sample();
      chk("rs_stays_idle", 32'({bus.oBusy, bus.oRomRe, bus.oValid}), 0);
    end

    // Asynchronous reset mid-frame with a read in flight
    do_start();
    run_words(1'b0, 7, 40, 1000, -1, cyc, dn, gp);
    @(posedge clock);
    #2;
    chk("pre_reset_inflight", 32'(bus.oRomRe || bus.oValid), 1);
    reset = 1'b1;
    #1;
    check_zero("midreset");
    model_clear();
    @(posedge clock);
    #1;
    check_zero("held_reset");
    reset = 1'b0;
    model_clear();
    do_start();
    run_words(1'b0, 15, 40, 1000, -1, cyc, dn, gp);
    chk("post_reset_cycles", cyc, 16);
    expect_done_then_idle("pr");

    // 1x1 image: vector table
    for (int k = 0; k < 13; k++) begin
      @(posedge clock);
      #1;
      tiny.iStart = 1'(vec[k].start);
      tiny.iReady = 1'(vec[k].ready);
      #1;
      chk($sformatf("t%0d_re", k),    32'(tiny.oRomRe), vec[k].re);
      chk($sformatf("t%0d_addr", k),  32'(tiny.oRomAddr), vec[k].addr);
      chk($sformatf("t%0d_valid", k), 32'(tiny.oValid), vec[k].valid);
      chk($sformatf("t%0d_done", k),  32'(tiny.oDone), vec[k].done);
      chk($sformatf("t%0d_busy", k),  32'(tiny.oBusy), vec[k].busy);
      if (vec[k].valid != 0) begin
        chk($sformatf("t%0d_data", k), 32'(tiny.oData), vec[k].data);
        chk($sformatf("t%0d_marks", k), 32'({tiny.oSof, tiny.oEol, tiny.oEof}),
            32'({1'(vec[k].sof), 1'(vec[k].eol), 1'(vec[k].eof)}));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/image_rom_streamer.md
# image_rom_streamer

Parametrised raster-scan reader for precomputed image and threshold ROMs; it replaces per-pixel coordinate lookup with a self-driven frame stream. On a start pulse it walks an IMG_W x IMG_H active window in raster order and drives addresses to an external synchronous ROM with a 1-cycle read latency. It returns each pixel with its coordinates and frame/line markers over a valid/ready handshake. Testbenches and the thresholding datapath use it as the pixel and threshold source.

## Interface
- WIDTH_BITS, 7, log2 of ROM row pitch (pitch = 1<<WIDTH_BITS)
- HEIGHT_BITS, 7, row index width
- IMG_W, 128, active columns, 1..(1<<WIDTH_BITS)
- IMG_H, 128, active rows, 1..(1<<HEIGHT_BITS)
- DATA_WIDTH, 8, pixel width
- ADDR_WIDTH, WIDTH_BITS+HEIGHT_BITS, ROM address width

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- iStart  in  1  begin a frame (sampled only in IDLE)
- iLoop  in  1  restart automatically after the last pixel (sampled at frame end)
- oBusy  out  1  high from start acceptance until the last pixel is popped
- oDone  out  1  one-cycle pulse after the last pixel is popped
- oRomAddr  out  ADDR_WIDTH  ROM address = (row<<WIDTH_BITS)+col
- oRomRe  out  1  read issued this cycle
- iRomData  in  DATA_WIDTH  ROM q, valid on the cycle after the issuing edge
- oValid  out  1  output word present
- iReady  in  1  consumer accepts; a pop occurs when oValid&&iReady
- oData  out  DATA_WIDTH  pixel
- oCol  out  WIDTH_BITS  pixel column
- oRow  out  HEIGHT_BITS  pixel row
- oSof  out  1  first pixel of the frame (0,0)
- oEol  out  1  col == IMG_W-1
- oEof  out  1  last pixel of the frame (IMG_W-1, IMG_H-1)

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: when iStart=1, clear the issue counters to (0,0) and go to RUN.
  - RUN: issue reads. After the read for (IMG_W-1, IMG_H-1) is issued, go to DRAIN.
  - DRAIN: when the FIFO is empty, no read is in flight, and the last pop has happened, pulse oDone. If iLoop=1, clear the counters and go to RUN; otherwise go to IDLE.
- Issue counter advances col first. At col == IMG_W-1 it wraps col to 0 and increments row. Columns IMG_W..pitch-1 are never addressed.
- In-flight tracker: a 1-bit flag (at most one read in flight) plus a pipeline that carries col, row, sof, eol and eof alongside the read.
- Output buffer is a 2-entry FIFO holding {data, col, row, sof, eol, eof}. ROM data is written into it on the cycle after issue. oData, oCol, oRow and the markers are the FIFO head.
- Issue rule: oRomRe = (state==RUN) && (count + inflight − pop < 2). This gives full throughput (1 pixel/cycle) while iReady is held high, and the FIFO never overflows.
- oBusy = (state != IDLE).
- iStart while busy is ignored.
- iLoop is sampled only at the DRAIN exit.
- Reset (asynchronous, any time, including mid-frame): state=IDLE, FIFO empty, in-flight flag cleared. All outputs are 0, including oValid, oBusy, oDone, oRomRe, oRomAddr, oData, oCol, oRow and the markers. Data returning from a read issued before reset is discarded.

## Timing
- Start edge k (IDLE, iStart=1): RUN from k; oRomRe=1 and oRomAddr=0 in cycle k→k+1.
- ROM q is valid after edge k+1 and written into the FIFO at edge k+2. oValid=1 after edge k+2, so start-to-first-valid latency is 2 cycles.
- With iReady held high: one pop per cycle and IMG_W*IMG_H consecutive valid cycles.
- oDone is high for exactly the cycle after the pop of the eof word; oBusy falls at the same edge unless looping.
- Backpressure with iReady=0: issue stops with at most 2 words held. Data and flags stay stable while oValid && !iReady.
- Loop: the first read of the next frame issues in the cycle after oDone's edge. This leaves a 2-cycle gap in oValid between frames.
- IMG_W=1: every pixel has oEol=1. IMG_W=IMG_H=1: a single word with sof, eol and eof all set.

## Test plan
- WIDTH_BITS=3, HEIGHT_BITS=2, IMG_W=5, IMG_H=3, iReady=1, ROM[a]=a. iStart at edge 0 → oValid from edge 2.
  - 15 consecutive words with data 0,1,2,3,4,8,…,12,16,…,20.
  - oSof only on the first word; oEol on cols 4; oEof on data 20.
  - oDone one cycle later; oBusy 0 after.
- Same config with iReady random at 50%. The captured stream must be identical to the previous case. Check: no drop or duplicate, data stable while stalled, oRomRe never issues with count + inflight − pop ≥ 2.
- iLoop=1 for two frames. A second identical frame follows, with a 2-cycle oValid gap and one oDone between frames. Drop iLoop, and the block goes IDLE after the second oDone.
- Assert reset at pixel 7 while a read is in flight. All outputs go 0 immediately. A new iStart restarts at (0,0) with no stale word delivered.
- Pulse iStart during RUN → no effect on the sequence. Set IMG_W=IMG_H=1 → a single word at addr 0 with sof, eol and eof all set.
